// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared encodings and melody table for melody_sequencer
package melody_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_NOTE, ST_GAP, ST_DONE} state_e;

  localparam int REST_BIT = 5;
  localparam int NOTE_MSB = 4;
  localparam int NOTE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  localparam logic [1:0] NOTE_LA440 = 2'd0;
  localparam logic [1:0] NOTE_RE    = 2'd1;
  localparam logic [1:0] NOTE_FA    = 2'd2;
  localparam logic [1:0] NOTE_LA880 = 2'd3;

  typedef logic [15:0][5:0] melody_table_t;

  function automatic logic [5:0] mk_entry(input logic rest, input logic [1:0] note,
                                          input logic [2:0] dur);
    return {rest, note, dur};
  endfunction

  // Listed from entry 15 down to entry 0; dur=0 marks the end of the tune.
  localparam melody_table_t MELODY_TABLE = {
    {8{6'd0}},
    mk_entry(1'b0, NOTE_LA440, 3'd3),
    mk_entry(1'b0, NOTE_RE,    3'd1),
    mk_entry(1'b0, NOTE_FA,    3'd1),
    mk_entry(1'b1, NOTE_LA440, 3'd1),
    mk_entry(1'b0, NOTE_LA880, 3'd2),
    mk_entry(1'b0, NOTE_FA,    3'd1),
    mk_entry(1'b0, NOTE_RE,    3'd1),
    mk_entry(1'b0, NOTE_LA440, 3'd2)
  };

endpackage

// File: rtl/beat_tick_gen.sv
// rtl/beat_tick_gen.sv - beat prescaler, one-cycle tick every TICK_DIV enabled cycles
module beat_tick_gen #(
  parameter int TICK_DIV = 97680,
  parameter int TW       = 17
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps a 16-entry melody table, driving note select and tone gate
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int            TICK_DIV = 97680,
  parameter int            GAP_CYC  = 1024,
  parameter int            TW       = 17,
  parameter melody_table_t TABLE    = MELODY_TABLE
) (
  input  logic       Clk_in,
  input  logic       Rst_n,
  input  logic       Play,
  input  logic       Stop,
  input  logic       Loop,
  output logic [1:0] Sw_out,
  output logic       Gate,
  output logic       Busy,
  output logic [3:0] Step_idx,
  output logic       Done
);

  localparam logic [TW-1:0] GAP_LAST = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;

  state_e        state_q;
  logic          play_q;
  logic [2:0]    beat_q;
  logic [TW-1:0] gap_q;
  logic [1:0]    sw_q;
  logic          gate_q;
  logic          busy_q;
  logic [3:0]    idx_q;
  logic          done_q;

  logic [5:0]    entry;
  logic          tick;
  logic          play_rise;
  logic          leave;
  logic          wrap_end;

  assign entry     = TABLE[idx_q];
  assign play_rise = Play && !play_q;
  // Entry finished: last beat tick when legato, otherwise end of the silent gap.
  assign leave     = (state_q == ST_NOTE && tick && beat_q == 3'd1 && GAP_CYC == 0) ||
                     (state_q == ST_GAP && gap_q == GAP_LAST);
  assign wrap_end  = (idx_q == 4'd15) && !Loop;

  beat_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_tick (
    .clk_i  (Clk_in),
    .rst_ni (Rst_n),
    .clr_i  (state_q != ST_NOTE),
    .en_i   (state_q == ST_NOTE),
    .tick_o (tick)
  );

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      play_q  <= 1'b0;
      beat_q  <= '0;
      gap_q   <= '0;
      sw_q    <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      play_q <= Play;
      done_q <= 1'b0;
      if (Stop && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
        gate_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            gate_q <= 1'b0;
            if (play_rise && !Stop) begin
              state_q <= ST_LOAD;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (entry[DUR_MSB:DUR_LSB] == 3'd0) begin
              if (Loop && idx_q != 4'd0) begin
                idx_q <= '0;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                gate_q  <= 1'b0;
              end
            end else begin
              sw_q    <= entry[NOTE_MSB:NOTE_LSB];
              gate_q  <= !entry[REST_BIT];
              beat_q  <= entry[DUR_MSB:DUR_LSB];
              state_q <= ST_NOTE;
            end
          end
          ST_NOTE: begin
            if (tick) begin
              if (beat_q != 3'd1) begin
                beat_q <= beat_q - 3'd1;
              end else if (GAP_CYC > 0) begin
                state_q <= ST_GAP;
                gate_q  <= 1'b0;
                gap_q   <= '0;
              end
            end
          end
          ST_GAP: begin
            if (!leave) gap_q <= gap_q + TW'(1);
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
        if (leave) begin
          idx_q   <= idx_q + 4'd1;
          state_q <= wrap_end ? ST_DONE : ST_LOAD;
          if (wrap_end) begin
            done_q <= 1'b1;
            gate_q <= 1'b0;
          end
        end
      end
    end
  end

  assign Sw_out   = sw_q;
  assign Gate     = gate_q;
  assign Busy     = busy_q;
  assign Step_idx = idx_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized bench for melody_sequencer against a schedule model
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int K_OUT  = 0;
  localparam int K_END  = 1;
  localparam int K_NEXT = 2;

  typedef struct packed {
    logic [1:0] kind;
    logic       done;
    logic       busy;
    logic       gate;
    logic [1:0] sw;
    logic [3:0] idx;
  } rec_t;

  function automatic melody_table_t mk_tbl_b();
    melody_table_t t;
    for (int i = 0; i < 16; i++) begin
      t[i] = {(i % 5) == 3, 2'(i % 4), 3'(1 + (i % 2))};
    end
    return t;
  endfunction

  localparam melody_table_t TBL_A = {
    {11{mk_entry(1'b0, NOTE_RE, 3'd1)}},
    6'd0,
    mk_entry(1'b0, NOTE_RE,    3'd1),
    mk_entry(1'b0, NOTE_LA880, 3'd2),
    mk_entry(1'b1, NOTE_RE,    3'd1),
    mk_entry(1'b0, NOTE_FA,    3'd3)
  };
  localparam melody_table_t TBL_B = mk_tbl_b();
  localparam melody_table_t TBL_C = '0;

  function automatic melody_table_t tbl_of(input int i);
    case (i)
      0:       return TBL_A;
      1:       return TBL_B;
      default: return TBL_C;
    endcase
  endfunction

  function automatic int td_of(input int i);
    case (i)
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int gap_of(input int i);
    case (i)
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  logic Clk_in = 1'b0;
  logic Rst_n;
  logic Play, Stop, Loop;
  logic [2:0][1:0] sw;
  logic [2:0]      gate, busy, done;
  logic [2:0][3:0] idx;

  always #5 Clk_in = ~Clk_in;

  melody_sequencer #(.TICK_DIV(4), .GAP_CYC(2), .TW(17), .TABLE(TBL_A)) u_a (
    .Clk_in(Clk_in), .Rst_n(Rst_n), .Play(Play), .Stop(Stop), .Loop(Loop),
    .Sw_out(sw[0]), .Gate(gate[0]), .Busy(busy[0]), .Step_idx(idx[0]), .Done(done[0]));
  melody_sequencer #(.TICK_DIV(2), .GAP_CYC(0), .TW(17), .TABLE(TBL_B)) u_b (
    .Clk_in(Clk_in), .Rst_n(Rst_n), .Play(Play), .Stop(Stop), .Loop(Loop),
    .Sw_out(sw[1]), .Gate(gate[1]), .Busy(busy[1]), .Step_idx(idx[1]), .Done(done[1]));
  melody_sequencer #(.TICK_DIV(4), .GAP_CYC(2), .TW(17), .TABLE(TBL_C)) u_c (
    .Clk_in(Clk_in), .Rst_n(Rst_n), .Play(Play), .Stop(Stop), .Loop(Loop),
    .Sw_out(sw[2]), .Gate(gate[2]), .Busy(busy[2]), .Step_idx(idx[2]), .Done(done[2]));

  int   checks = 0;
  int   errors = 0;
  rec_t sched[3][$];
  logic exp_gate[3], exp_busy[3], exp_done[3];
  logic [1:0] exp_sw[3];
  logic [3:0] exp_idx[3];
  logic play_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk_rec(input int kind, input logic d, input logic b, input logic g,
                                  input logic [1:0] s, input logic [3:0] x);
    return {2'(kind), d, b, g, s, x};
  endfunction

  // Expand one table entry into its per-cycle expected outputs, ending with a decision marker.
  task automatic plan_entry(input int i, input logic [3:0] x);
    melody_table_t t;
    logic [5:0] e;
    t = tbl_of(i);
    e = t[x];
    sched[i].push_back(mk_rec(K_OUT, 1'b0, 1'b1, exp_gate[i], exp_sw[i], x));
    if (e[2:0] == 3'd0) begin
      sched[i].push_back(mk_rec(K_END, 1'b0, 1'b0, 1'b0, 2'd0, x));
    end else begin
      for (int c = 0; c < int'(e[2:0]) * td_of(i); c++)
        sched[i].push_back(mk_rec(K_OUT, 1'b0, 1'b1, !e[5], e[4:3], x));
      for (int c = 0; c < gap_of(i); c++)
        sched[i].push_back(mk_rec(K_OUT, 1'b0, 1'b1, 1'b0, e[4:3], x));
      sched[i].push_back(mk_rec(K_NEXT, 1'b0, 1'b0, 1'b0, 2'd0, x));
    end
  endtask

  function automatic rec_t finish(input int i, input logic [3:0] x);
    sched[i].push_back(mk_rec(K_OUT, 1'b0, 1'b0, 1'b0, exp_sw[i], x));
    return mk_rec(K_OUT, 1'b1, 1'b1, 1'b0, exp_sw[i], x);
  endfunction

  task automatic model_step(input int i);
    rec_t r;
    if (sched[i].size() == 0) begin
      if (Play && !play_prev && !Stop) begin
        plan_entry(i, 4'd0);
        r = sched[i].pop_front();
      end else begin
        r = mk_rec(K_OUT, 1'b0, 1'b0, 1'b0, exp_sw[i], exp_idx[i]);
      end
    end else if (Stop) begin
      sched[i].delete();
      r = mk_rec(K_OUT, 1'b0, 1'b0, 1'b0, exp_sw[i], exp_idx[i]);
    end else begin
      r = sched[i].pop_front();
      if (r.kind == 2'(K_END)) begin
        if (Loop && r.idx != 4'd0) begin
          plan_entry(i, 4'd0);
          r = sched[i].pop_front();
        end else begin
          r = finish(i, r.idx);
        end
      end else if (r.kind == 2'(K_NEXT)) begin
        if (r.idx != 4'd15) begin
          plan_entry(i, r.idx + 4'd1);
          r = sched[i].pop_front();
        end else if (Loop) begin
          plan_entry(i, 4'd0);
          r = sched[i].pop_front();
        end else begin
          r = finish(i, 4'd0);
        end
      end
    end
    exp_gate[i] = r.gate;
    exp_busy[i] = r.busy;
    exp_done[i] = r.done;
    exp_sw[i]   = r.sw;
    exp_idx[i]  = r.idx;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_dut%0d", tag, i),
          {23'd0, done[i], busy[i], gate[i], sw[i], idx[i]},
          {23'd0, exp_done[i], exp_busy[i], exp_gate[i], exp_sw[i], exp_idx[i]});
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      sched[i].delete();
      exp_gate[i] = 1'b0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
      exp_sw[i]   = 2'd0;
      exp_idx[i]  = 4'd0;
    end
    play_prev = 1'b0;
    check_all("reset");
    repeat (3) @(negedge Clk_in);
    Rst_n = 1'b1;
  endtask

  task automatic cycle(input logic p, input logic s, input logic l);
    Play = p;
    Stop = s;
    Loop = l;
    @(posedge Clk_in);
    for (int i = 0; i < 3; i++) model_step(i);
    play_prev = p;
    @(negedge Clk_in);
    check_all("run");
  endtask

  initial begin
    logic p_r, l_r;
    Rst_n = 1'b0;
    Play  = 1'b0;
    Stop  = 1'b0;
    Loop  = 1'b0;
    @(negedge Clk_in);
    do_reset();

    repeat (50) cycle(1'b0, 1'b0, 1'b0);

    // Play held high across the whole run: no restart after Done.
    repeat (200) cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);

    cycle(1'b1, 1'b0, 1'b1);
    repeat (300) cycle(1'b0, 1'b0, 1'b1);
    repeat (200) cycle(1'b0, 1'b0, 1'b0);

    cycle(1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    cycle(1'b1, 1'b1, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    p_r = 1'b0;
    l_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) p_r = ~p_r;
      if ($urandom_range(199) == 0) l_r = ~l_r;
      cycle(p_r, $urandom_range(99) == 0, l_r);
    end

    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0, 1'b1);
    do_reset();
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (150) cycle(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
